isdu_param: RTL and testbench

ISDU_PARAM -- requirements
Module: isdu_param

---
 rtl/isdu_pkg.sv | 59 +++++
 rtl/mem_wait_ctr.sv | 34 +++
 rtl/isdu_param.sv | 190 +++++++++++++++++++
 tb/tb_isdu_param.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isdu_pkg.sv
// Shared types for the ISDU control unit: state encoding, datapath control word,
// opcode values and state classification helpers.
package isdu_pkg;

    localparam int unsigned CTR_W = 4;

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH, S_FETCH_RD, S_LOAD_IR, S_PAUSE_IR1, S_PAUSE_IR2,
        S_DECODE, S_ADD, S_AND, S_NOT, S_BR_TEST, S_BR_TAKE, S_JMP,
        S_JSR_LINK, S_JSR_PC, S_LDR_ADDR, S_LDR_RD, S_LDR_WB,
        S_STR_ADDR, S_STR_DATA, S_STR_WR, S_LDI_ADDR, S_LDI_RD, S_LDI_IND,
        S_STI_ADDR, S_STI_RD, S_STI_IND, S_LED_LD, S_LED_WAIT, S_LED_REL
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_STI   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    function automatic logic is_read(input state_t s);
        return s inside {S_FETCH_RD, S_LDR_RD, S_LDI_RD, S_STI_RD};
    endfunction

    function automatic logic is_write(input state_t s);
        return s == S_STR_WR;
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Down-counter shared by all SRAM access states; zero marks the final access cycle.
module mem_wait_ctr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/isdu_param.sv
// Instruction sequencing/decode unit: walks fetch, decode and execute states and
// drives datapath controls and active-low SRAM strobes with a parameterised access length.
module isdu_param
    import isdu_pkg::*;
#(
    parameter int unsigned MEM_WAIT    = 2,
    parameter bit          PAUSE_FETCH = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output ctrl_t       Ctrl,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output state_t      State_o
);

    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(MEM_WAIT - 1);

    state_t state_q, state_d;
    logic   ctr_zero, ctr_load, ctr_dec;
    logic   unused_ir;

    assign unused_ir = ^{IR[11:6], IR[4:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALTED:    if (Run) state_d = S_FETCH;
            S_FETCH:     state_d = S_FETCH_RD;
            S_FETCH_RD:  if (ctr_zero) state_d = S_LOAD_IR;
            S_LOAD_IR:   state_d = PAUSE_FETCH ? S_PAUSE_IR1 : S_DECODE;
            S_PAUSE_IR1: if (Continue) state_d = S_PAUSE_IR2;
            S_PAUSE_IR2: if (!Continue) state_d = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_BR:    state_d = S_BR_TEST;
                    OP_JMP:   state_d = S_JMP;
                    OP_JSR:   state_d = S_JSR_LINK;
                    OP_LDR:   state_d = S_LDR_ADDR;
                    OP_STR:   state_d = S_STR_ADDR;
                    OP_LDI:   state_d = S_LDI_ADDR;
                    OP_STI:   state_d = S_STI_ADDR;
                    OP_PAUSE: state_d = S_LED_LD;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_JMP, S_JSR_PC, S_BR_TAKE, S_LDR_WB: state_d = S_FETCH;
            S_BR_TEST:   state_d = BEN ? S_BR_TAKE : S_FETCH;
            S_JSR_LINK:  state_d = S_JSR_PC;
            S_LDR_ADDR:  state_d = S_LDR_RD;
            S_LDR_RD:    if (ctr_zero) state_d = S_LDR_WB;
            S_STR_ADDR:  state_d = S_STR_DATA;
            S_STR_DATA:  state_d = S_STR_WR;
            S_STR_WR:    if (ctr_zero) state_d = S_FETCH;
            // Indirect forms rejoin the plain LDR/STR paths once MAR holds the pointer.
            S_LDI_ADDR:  state_d = S_LDI_RD;
            S_LDI_RD:    if (ctr_zero) state_d = S_LDI_IND;
            S_LDI_IND:   state_d = S_LDR_RD;
            S_STI_ADDR:  state_d = S_STI_RD;
            S_STI_RD:    if (ctr_zero) state_d = S_STI_IND;
            S_STI_IND:   state_d = S_STR_DATA;
            S_LED_LD:    state_d = S_LED_WAIT;
            S_LED_WAIT:  if (Continue) state_d = S_LED_REL;
            S_LED_REL:   if (!Continue) state_d = S_FETCH;
            default:     state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // Reload on entry to any access state, count down while still inside it.
    always_comb begin
        ctr_load = (is_read(state_d) || is_write(state_d)) && (state_d != state_q);
        ctr_dec  = (is_read(state_q) || is_write(state_q)) && !ctr_zero;
    end

    mem_wait_ctr #(.WIDTH(CTR_W)) u_wait_ctr (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (ctr_load),
        .load_val (WAIT_LOAD),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    always_comb begin
        Ctrl   = CTRL_IDLE;
        Mem_OE = 1'b1;
        Mem_WE = 1'b1;
        case (state_q)
            S_FETCH: begin
                Ctrl.gate_pc = 1'b1;
                Ctrl.ld_mar  = 1'b1;
                Ctrl.pcmux   = 2'b10;
                Ctrl.ld_pc   = 1'b1;
            end
            S_FETCH_RD, S_LDR_RD, S_LDI_RD, S_STI_RD: begin
                Mem_OE      = 1'b0;
                Ctrl.ld_mdr = ctr_zero;
            end
            S_STR_WR: Mem_WE = 1'b0;
            S_LOAD_IR: begin
                Ctrl.gate_mdr = 1'b1;
                Ctrl.ld_ir    = 1'b1;
            end
            S_DECODE: Ctrl.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                Ctrl.sr1mux   = 1'b1;
                Ctrl.sr2mux   = (state_q == S_NOT) ? 1'b0 : IR[5];
                Ctrl.aluk     = (state_q == S_ADD) ? 2'b00 : (state_q == S_AND) ? 2'b01 : 2'b10;
                Ctrl.gate_alu = 1'b1;
                Ctrl.ld_reg   = 1'b1;
                Ctrl.ld_cc    = 1'b1;
            end
            S_BR_TAKE: begin
                Ctrl.addr1mux = 1'b1;
                Ctrl.addr2mux = 2'b01;
                Ctrl.pcmux    = 2'b01;
                Ctrl.ld_pc    = 1'b1;
            end
            S_JMP: begin
                Ctrl.sr1mux   = 1'b1;
                Ctrl.addr2mux = 2'b11;
                Ctrl.pcmux    = 2'b01;
                Ctrl.ld_pc    = 1'b1;
            end
            S_JSR_LINK: begin
                Ctrl.gate_pc = 1'b1;
                Ctrl.drmux   = 1'b1;
                Ctrl.ld_reg  = 1'b1;
            end
            S_JSR_PC: begin
                Ctrl.addr1mux = 1'b1;
                Ctrl.addr2mux = 2'b00;
                Ctrl.pcmux    = 2'b01;
                Ctrl.ld_pc    = 1'b1;
            end
            S_LDR_ADDR, S_STR_ADDR: begin
                Ctrl.sr1mux      = 1'b1;
                Ctrl.addr2mux    = 2'b10;
                Ctrl.gate_marmux = 1'b1;
                Ctrl.ld_mar      = 1'b1;
            end
            S_LDR_WB: begin
                Ctrl.gate_mdr = 1'b1;
                Ctrl.ld_reg   = 1'b1;
                Ctrl.ld_cc    = 1'b1;
            end
            S_STR_DATA: begin
                Ctrl.aluk     = 2'b11;
                Ctrl.gate_alu = 1'b1;
                Ctrl.ld_mdr   = 1'b1;
            end
            S_LDI_ADDR, S_STI_ADDR: begin
                Ctrl.addr1mux    = 1'b1;
                Ctrl.addr2mux    = 2'b01;
                Ctrl.gate_marmux = 1'b1;
                Ctrl.ld_mar      = 1'b1;
            end
            S_LDI_IND, S_STI_IND: begin
                Ctrl.gate_mdr = 1'b1;
                Ctrl.ld_mar   = 1'b1;
            end
            S_LED_LD: Ctrl.ld_led = 1'b1;
            default: ;
        endcase
    end

    assign Mem_CE  = 1'b0;
    assign Mem_UB  = 1'b0;
    assign Mem_LB  = 1'b0;
    assign State_o = state_q;

endmodule

// File: tb/tb_isdu_param.sv
// Bench for isdu_param: three instances (MEM_WAIT 3 / 2 / 1, the last with fetch pause)
// driven in parallel, checked with a vector table, a trace model and corner sequences.
`timescale 1ns/1ps
module tb_isdu_param;
    import isdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, run = 1'b0, cont = 1'b0, ben = 1'b0;
    logic [15:0] ir = '0;

    ctrl_t  ctrl_a, ctrl_b, ctrl_c;
    logic   ce_a, ub_a, lb_a, oe_a, we_a;
    logic   ce_b, ub_b, lb_b, oe_b, we_b;
    logic   ce_c, ub_c, lb_c, oe_c, we_c;
    state_t st_a, st_b, st_c;

    isdu_param #(.MEM_WAIT(3), .PAUSE_FETCH(1'b0)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .Run(run), .Continue(cont), .IR(ir), .BEN(ben),
        .Ctrl(ctrl_a), .Mem_CE(ce_a), .Mem_UB(ub_a), .Mem_LB(lb_a), .Mem_OE(oe_a),
        .Mem_WE(we_a), .State_o(st_a));

    isdu_param dut_b (
        .Clk(clk), .Reset_n(rst_n), .Run(run), .Continue(cont), .IR(ir), .BEN(ben),
        .Ctrl(ctrl_b), .Mem_CE(ce_b), .Mem_UB(ub_b), .Mem_LB(lb_b), .Mem_OE(oe_b),
        .Mem_WE(we_b), .State_o(st_b));

    isdu_param #(.MEM_WAIT(1), .PAUSE_FETCH(1'b1)) dut_c (
        .Clk(clk), .Reset_n(rst_n), .Run(run), .Continue(cont), .IR(ir), .BEN(ben),
        .Ctrl(ctrl_c), .Mem_CE(ce_c), .Mem_UB(ub_c), .Mem_LB(lb_c), .Mem_OE(oe_c),
        .Mem_WE(we_c), .State_o(st_c));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset everything, pulse Run; returns sampled in the first FETCH cycle.
    task automatic start();
        rst_n = 1'b0;
        run   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        run   = 1'b1;
        step();
        run   = 1'b0;
    endtask

    function automatic logic is_fetch(input ctrl_t c);
        return c.ld_pc && (c.pcmux == 2'b10);
    endfunction

    // ---------------- reference trace model ----------------
    typedef struct packed {
        ctrl_t c;
        logic  oe;
        logic  we;
    } exp_t;

    exp_t tr_a[$];
    exp_t tr_b[$];

    task automatic push_w(input int w, input ctrl_t c, input logic oe, input logic we);
        exp_t e;
        e.c  = c;
        e.oe = oe;
        e.we = we;
        if (w == 0) tr_a.push_back(e);
        else        tr_b.push_back(e);
    endtask

    task automatic push_read(input int w, input int mw);
        ctrl_t c;
        for (int j = 0; j < mw; j++) begin
            c = '0;
            c.ld_mdr = (j == mw - 1);
            push_w(w, c, 1'b0, 1'b1);
        end
    endtask

    task automatic push_write(input int w, input int mw);
        for (int j = 0; j < mw; j++) push_w(w, '0, 1'b1, 1'b0);
    endtask

    task automatic build(input int w, input int mw, input logic [15:0] op_ir, input bit b);
        ctrl_t c, fetch_c;
        if (w == 0) tr_a.delete(); else tr_b.delete();
        fetch_c = '0;
        fetch_c.gate_pc = 1'b1; fetch_c.ld_mar = 1'b1; fetch_c.pcmux = 2'b10; fetch_c.ld_pc = 1'b1;
        push_w(w, fetch_c, 1'b1, 1'b1);
        push_read(w, mw);
        c = '0; c.gate_mdr = 1'b1; c.ld_ir = 1'b1; push_w(w, c, 1'b1, 1'b1);
        c = '0; c.ld_ben = 1'b1; push_w(w, c, 1'b1, 1'b1);
        c = '0;
        case (op_ir[15:12])
            4'b0001, 4'b0101, 4'b1001: begin
                c.sr1mux = 1'b1; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.sr2mux = (op_ir[15:12] == 4'b1001) ? 1'b0 : op_ir[5];
                c.aluk   = (op_ir[15:12] == 4'b0001) ? 2'b00 :
                           (op_ir[15:12] == 4'b0101) ? 2'b01 : 2'b10;
                push_w(w, c, 1'b1, 1'b1);
            end
            4'b0000: begin
                push_w(w, '0, 1'b1, 1'b1);
                if (b) begin
                    c.addr1mux = 1'b1; c.addr2mux = 2'b01; c.pcmux = 2'b01; c.ld_pc = 1'b1;
                    push_w(w, c, 1'b1, 1'b1);
                end
            end
            4'b1100: begin
                c.sr1mux = 1'b1; c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1'b1;
                push_w(w, c, 1'b1, 1'b1);
            end
            4'b0100: begin
                c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
                push_w(w, c, 1'b1, 1'b1);
                c = '0; c.addr1mux = 1'b1; c.pcmux = 2'b01; c.ld_pc = 1'b1;
                push_w(w, c, 1'b1, 1'b1);
            end
            4'b0110, 4'b0111: begin
                c.sr1mux = 1'b1; c.addr2mux = 2'b10; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
                push_w(w, c, 1'b1, 1'b1);
            end
            4'b1010, 4'b1011: begin
                c.addr1mux = 1'b1; c.addr2mux = 2'b01; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
                push_w(w, c, 1'b1, 1'b1);
                push_read(w, mw);
                c = '0; c.gate_mdr = 1'b1; c.ld_mar = 1'b1;
                push_w(w, c, 1'b1, 1'b1);
            end
            default: ;
        endcase
        if (op_ir[15:12] inside {4'b0110, 4'b1010}) begin
            push_read(w, mw);
            c = '0; c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            push_w(w, c, 1'b1, 1'b1);
        end
        if (op_ir[15:12] inside {4'b0111, 4'b1011}) begin
            c = '0; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
            push_w(w, c, 1'b1, 1'b1);
            push_write(w, mw);
        end
        push_w(w, fetch_c, 1'b1, 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] ir;
        bit          ben;
        int          cyc_a, oe_a, we_a, ldpc, ldmdr, cyc_b, oe_b, we_b;
    } vec_t;

    vec_t tbl[13];
    int   oplist[15];
    int   ca, cb, oa, ob, wa, wb, pa, ma, n, led_seen;
    bit   da, db;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h1283, 1'b0,  7, 3, 0, 1, 1,  6, 2, 0};
        tbl[1]  = '{16'h5283, 1'b1,  7, 3, 0, 1, 1,  6, 2, 0};
        tbl[2]  = '{16'h927F, 1'b0,  7, 3, 0, 1, 1,  6, 2, 0};
        tbl[3]  = '{16'h0405, 1'b0,  7, 3, 0, 1, 1,  6, 2, 0};
        tbl[4]  = '{16'h0405, 1'b1,  8, 3, 0, 2, 1,  7, 2, 0};
        tbl[5]  = '{16'hC1C0, 1'b0,  7, 3, 0, 2, 1,  6, 2, 0};
        tbl[6]  = '{16'h4800, 1'b0,  8, 3, 0, 2, 1,  7, 2, 0};
        tbl[7]  = '{16'h6283, 1'b0, 11, 6, 0, 1, 2,  9, 4, 0};
        tbl[8]  = '{16'h7283, 1'b0, 11, 3, 3, 1, 2,  9, 2, 2};
        tbl[9]  = '{16'hA203, 1'b0, 15, 9, 0, 1, 3, 12, 6, 0};
        tbl[10] = '{16'hB203, 1'b0, 15, 6, 3, 1, 3, 12, 4, 2};
        tbl[11] = '{16'h3000, 1'b0,  6, 3, 0, 1, 1,  5, 2, 0};
        tbl[12] = '{16'hF025, 1'b1,  6, 3, 0, 1, 1,  5, 2, 0};
        oplist  = '{1, 5, 9, 0, 12, 4, 6, 7, 10, 11, 2, 3, 8, 14, 15};

        // Reset state with Run held high: stays halted, all outputs idle.
        rst_n = 1'b0; run = 1'b1;
        step();
        step();
        check("rst_state_a", st_a, S_HALTED);
        check("rst_outs_a", {ctrl_a, oe_a, we_a, ce_a, ub_a, lb_a}, {22'h0, 2'b11, 3'b000});
        check("rst_outs_b", {ctrl_b, oe_b, we_b}, {22'h0, 2'b11});
        check("rst_outs_c", {ctrl_c, oe_c, we_c}, {22'h0, 2'b11});
        rst_n = 1'b1;
        step();
        check("run_thru_reset_a", st_a, S_FETCH);
        check("run_thru_reset_c", st_c, S_FETCH);
        run = 1'b0;

        // Table: per-instruction cycle counts and strobe totals, FETCH to next FETCH.
        for (int i = 0; i < 13; i++) begin
            ir = tbl[i].ir; ben = tbl[i].ben; cont = 1'b0;
            start();
            ca = 0; cb = 0; oa = 0; ob = 0; wa = 0; wb = 0; pa = 0; ma = 0; da = 0; db = 0;
            for (int k = 0; k < 40 && !(da && db); k++) begin
                if (!da) begin
                    if (k > 0 && is_fetch(ctrl_a)) da = 1;
                    else begin
                        ca++; oa += int'(!oe_a); wa += int'(!we_a);
                        pa += int'(ctrl_a.ld_pc); ma += int'(ctrl_a.ld_mdr);
                    end
                end
                if (!db) begin
                    if (k > 0 && is_fetch(ctrl_b)) db = 1;
                    else begin
                        cb++; ob += int'(!oe_b); wb += int'(!we_b);
                    end
                end
                step();
            end
            check($sformatf("tbl_done ir=%h", tbl[i].ir), {da, db}, 2'b11);
            check($sformatf("tbl_cyc_a ir=%h", tbl[i].ir), ca, tbl[i].cyc_a);
            check($sformatf("tbl_oe_a ir=%h", tbl[i].ir), oa, tbl[i].oe_a);
            check($sformatf("tbl_we_a ir=%h", tbl[i].ir), wa, tbl[i].we_a);
            check($sformatf("tbl_ldpc_a ir=%h", tbl[i].ir), pa, tbl[i].ldpc);
            check($sformatf("tbl_ldmdr_a ir=%h", tbl[i].ir), ma, tbl[i].ldmdr);
            check($sformatf("tbl_cyc_b ir=%h", tbl[i].ir), cb, tbl[i].cyc_b);
            check($sformatf("tbl_oe_b ir=%h", tbl[i].ir), ob, tbl[i].oe_b);
            check($sformatf("tbl_we_b ir=%h", tbl[i].ir), wb, tbl[i].we_b);
        end

        // Random instructions against the trace model, cycle by cycle.
        for (int r = 0; r < 50; r++) begin
            ir   = {4'(oplist[$urandom_range(14, 0)]), 12'($urandom)};
            ben  = 1'($urandom);
            cont = 1'($urandom);
            build(0, 3, ir, ben);
            build(1, 2, ir, ben);
            start();
            n = (tr_a.size() > tr_b.size()) ? tr_a.size() : tr_b.size();
            for (int k = 0; k < n; k++) begin
                if (k < tr_a.size())
                    check($sformatf("rand_a ir=%h ben=%0d cyc=%0d", ir, ben, k),
                          {ctrl_a, oe_a, we_a, ce_a, ub_a, lb_a}, {tr_a[k], 3'b000});
                if (k < tr_b.size())
                    check($sformatf("rand_b ir=%h ben=%0d cyc=%0d", ir, ben, k),
                          {ctrl_b, oe_b, we_b, ce_b, ub_b, lb_b}, {tr_b[k], 3'b000});
                step();
            end
        end

        // MEM_WAIT=3 ADD: OE low three cycles, LD_IR at cycle 5, ADD at cycle 7.
        ir = 16'h1283; ben = 1'b0; cont = 1'b0;
        start();
        oa = 0; pa = 0; ma = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            oa += int'(!oe_a);
            if (ctrl_a.ld_ir) pa = cyc;
            if (ctrl_a.gate_alu && ctrl_a.ld_reg && ctrl_a.ld_cc && ctrl_a.aluk == 2'b00) ma = cyc;
            step();
        end
        check("add_oe_cycles", oa, 3);
        check("add_ld_ir_cycle", pa, 5);
        check("add_exec_cycle", ma, 7);

        // PAUSE with Continue already high: one LD_LED, then stall until release.
        ir = 16'hD000; cont = 1'b1;
        start();
        for (int k = 0; k < 6; k++) step();
        check("led_ld_pulse", ctrl_a.ld_led, 1'b1);
        led_seen = 0;
        step();
        check("led_wait_state", st_a, S_LED_WAIT);
        for (int k = 0; k < 8; k++) begin
            led_seen += int'(ctrl_a.ld_led);
            step();
        end
        check("led_single_pulse", led_seen, 0);
        check("led_hold_release", st_a, S_LED_REL);
        cont = 1'b0;
        step();
        check("led_release_fetch", is_fetch(ctrl_a), 1'b1);

        // PAUSE with Continue low: wait for high, then for low.
        cont = 1'b0;
        start();
        for (int k = 0; k < 7; k++) step();
        for (int k = 0; k < 4; k++) step();
        check("led_wait_stall", st_a, S_LED_WAIT);
        cont = 1'b1;
        step();
        step();
        check("led_rel_stall", st_a, S_LED_REL);
        cont = 1'b0;
        step();
        check("led_rel_fetch", st_a, S_FETCH);

        // Reset during the second cycle of an LDR data read.
        ir = 16'h6283; cont = 1'b0;
        start();
        for (int k = 0; k < 7; k++) step();
        check("ldr_rd_first", {st_a, oe_a, ctrl_a.ld_mdr}, {S_LDR_RD, 1'b0, 1'b0});
        step();
        check("ldr_rd_second", {st_a, oe_a, ctrl_a.ld_mdr}, {S_LDR_RD, 1'b0, 1'b0});
        rst_n = 1'b0;
        step();
        check("ldr_rst_state", st_a, S_HALTED);
        check("ldr_rst_outs", {ctrl_a, oe_a, we_a}, {22'h0, 2'b11});
        rst_n = 1'b1;
        ma = 0;
        for (int k = 0; k < 3; k++) begin
            ma += int'(ctrl_a.ld_mdr);
            step();
        end
        check("ldr_rst_no_mdr", ma, 0);
        check("ldr_rst_stays_halted", st_a, S_HALTED);

        // MEM_WAIT=1 with fetch pause on instance C.
        ir = 16'h1283; cont = 1'b0;
        start();
        step();
        check("mw1_read", {oe_c, ctrl_c.ld_mdr}, 2'b01);
        step();
        check("mw1_load_ir", {oe_c, ctrl_c.ld_ir}, 2'b11);
        step();
        check("pause_ir1_enter", st_c, S_PAUSE_IR1);
        for (int k = 0; k < 3; k++) step();
        check("pause_ir1_hold", st_c, S_PAUSE_IR1);
        cont = 1'b1;
        step();
        step();
        check("pause_ir2_hold", st_c, S_PAUSE_IR2);
        cont = 1'b0;
        step();
        check("pause_decode", {st_c, ctrl_c.ld_ben}, {S_DECODE, 1'b1});
        step();
        check("pause_add", {st_c, ctrl_c.gate_alu, ctrl_c.ld_reg}, {S_ADD, 2'b11});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
